keccak_arb: RTL and testbench

Four-requester arbiter and sequencer that shares one `keccak` core among the Kyber hash consumers (G, H, PRF, XOF/KDF).
- Grants the core to one requester per transaction using round-robin selection.
- Holds the grant until the core signals completion, and routes the absorb and squeeze streams between the winner and the core.
- Sits between the hash consumers and the single `keccak` instance.

---
 rtl/keccak_arb.sv | 143 ++++++++++++++
 tb/tb_keccak_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_arb.sv
// Round-robin arbiter/sequencer sharing one keccak core among four hash consumers.
// Optional KECCAK_ARB_PRIO0_EN: requester 0 gets strict priority, 1-3 round-robin.
module keccak_arb #(
  parameter int unsigned NREQ = 4
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [3:0]     i_req,
  input  logic [7:0]     i_req_mode,
  input  logic [255:0]   i_req_ibytes,
  input  logic [3:0]     i_req_ibytes_valid,
  input  logic [43:0]    i_req_ibytes_len,
  input  logic [39:0]    i_req_obytes_len,
  output logic [3:0]     o_gnt,
  output logic [1:0]     o_gnt_id,
  output logic           o_busy,
  output logic [3:0]     o_req_ibytes_ready,
  output logic [63:0]    o_req_obytes,
  output logic [3:0]     o_req_obytes_valid,
  output logic [3:0]     o_req_obytes_done,
  output logic [1:0]     o_kc_mode,
  output logic [63:0]    o_kc_ibytes,
  output logic           o_kc_ibytes_valid,
  output logic [10:0]    o_kc_ibytes_len,
  output logic [9:0]     o_kc_obytes_len,
  input  logic           i_kc_ibytes_ready,
  input  logic [63:0]    i_kc_obytes,
  input  logic           i_kc_obytes_valid,
  input  logic           i_kc_obytes_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_rr_ptr;
  logic [3:0]  r_gnt;
  logic [1:0]  r_gnt_id;
  logic [1:0]  r_kc_mode;
  logic [10:0] r_kc_ibytes_len;
  logic [9:0]  r_kc_obytes_len;

  logic        w_found;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic        w_busy;

  assign w_busy = (r_state == BUSY);

  // First asserted request at or after r_rr_ptr, wrapping mod 4.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
`ifdef KECCAK_ARB_PRIO0_EN
    if (i_req[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        w_idx = r_rr_ptr + 2'(i);
        if (!w_found && (w_idx != 2'd0) && i_req[w_idx]) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end
      end
    end
`else
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = BUSY;
      BUSY:    if (i_kc_obytes_done) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state         <= IDLE;
      r_rr_ptr        <= '0;
      r_gnt           <= '0;
      r_gnt_id        <= '0;
      r_kc_mode       <= '0;
      r_kc_ibytes_len <= '0;
      r_kc_obytes_len <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) begin
        r_gnt           <= 4'b0001 << w_win;
        r_gnt_id        <= w_win;
        r_kc_mode       <= i_req_mode[{w_win, 1'b0} +: 2];
        r_kc_ibytes_len <= i_req_ibytes_len[w_win * 11 +: 11];
        r_kc_obytes_len <= i_req_obytes_len[w_win * 10 +: 10];
      end
      if (w_busy && i_kc_obytes_done) begin
        r_gnt <= '0;
`ifdef KECCAK_ARB_PRIO0_EN
        if (r_gnt_id != 2'd0) r_rr_ptr <= r_gnt_id + 2'd1;
`else
        r_rr_ptr <= r_gnt_id + 2'd1;
`endif
      end
    end
  end

  always_comb begin
    o_kc_ibytes        = i_req_ibytes[{r_gnt_id, 6'b0} +: 64];
    o_kc_ibytes_valid  = 1'b0;
    o_req_ibytes_ready = '0;
    o_req_obytes_valid = '0;
    o_req_obytes_done  = '0;
    if (w_busy) begin
      o_kc_ibytes_valid            = i_req_ibytes_valid[r_gnt_id];
      o_req_ibytes_ready[r_gnt_id] = i_kc_ibytes_ready;
      o_req_obytes_valid[r_gnt_id] = i_kc_obytes_valid;
      o_req_obytes_done[r_gnt_id]  = i_kc_obytes_done;
    end
  end

  assign o_gnt           = r_gnt;
  assign o_gnt_id        = r_gnt_id;
  assign o_busy          = w_busy;
  assign o_req_obytes    = i_kc_obytes;
  assign o_kc_mode       = r_kc_mode;
  assign o_kc_ibytes_len = r_kc_ibytes_len;
  assign o_kc_obytes_len = r_kc_obytes_len;

endmodule

// File: tb/tb_keccak_arb.sv
// Self-checking bench for keccak_arb: the bench plays both the requesters and the core.
module tb_keccak_arb;

  logic           clk = 1'b0;
  logic           i_rstn;
  logic [3:0]     i_req;
  logic [7:0]     i_req_mode;
  logic [255:0]   i_req_ibytes;
  logic [3:0]     i_req_ibytes_valid;
  logic [43:0]    i_req_ibytes_len;
  logic [39:0]    i_req_obytes_len;
  logic [3:0]     o_gnt;
  logic [1:0]     o_gnt_id;
  logic           o_busy;
  logic [3:0]     o_req_ibytes_ready;
  logic [63:0]    o_req_obytes;
  logic [3:0]     o_req_obytes_valid;
  logic [3:0]     o_req_obytes_done;
  logic [1:0]     o_kc_mode;
  logic [63:0]    o_kc_ibytes;
  logic           o_kc_ibytes_valid;
  logic [10:0]    o_kc_ibytes_len;
  logic [9:0]     o_kc_obytes_len;
  logic           i_kc_ibytes_ready;
  logic [63:0]    i_kc_obytes;
  logic           i_kc_obytes_valid;
  logic           i_kc_obytes_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  keccak_arb #(.NREQ(4)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_req(i_req), .i_req_mode(i_req_mode),
    .i_req_ibytes(i_req_ibytes), .i_req_ibytes_valid(i_req_ibytes_valid),
    .i_req_ibytes_len(i_req_ibytes_len), .i_req_obytes_len(i_req_obytes_len),
    .o_gnt(o_gnt), .o_gnt_id(o_gnt_id), .o_busy(o_busy),
    .o_req_ibytes_ready(o_req_ibytes_ready), .o_req_obytes(o_req_obytes),
    .o_req_obytes_valid(o_req_obytes_valid), .o_req_obytes_done(o_req_obytes_done),
    .o_kc_mode(o_kc_mode), .o_kc_ibytes(o_kc_ibytes), .o_kc_ibytes_valid(o_kc_ibytes_valid),
    .o_kc_ibytes_len(o_kc_ibytes_len), .o_kc_obytes_len(o_kc_obytes_len),
    .i_kc_ibytes_ready(i_kc_ibytes_ready), .i_kc_obytes(i_kc_obytes),
    .i_kc_obytes_valid(i_kc_obytes_valid), .i_kc_obytes_done(i_kc_obytes_done)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Slot k: mode=k, ibytes_len=31+k, obytes_len=30+k (slot 2: mode 2, 33, 32).
  task automatic set_words(input int unsigned word);
    for (int k = 0; k < 4; k++)
      i_req_ibytes[64*k +: 64] = {32'(k), 32'(word)};
  endtask

  task automatic wait_grant(output int unsigned cur, input int unsigned exp_wait);
    int unsigned cnt = 0;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      cur = 0;
    end else cur = exp_q.pop_front();
    do begin
      @(negedge clk);
      cnt++;
    end while (o_gnt == 4'b0 && cnt < 20);
    if (cnt >= 20) check("gnt_timeout", 1, 0);
    if (exp_wait != 0) check("gnt_wait", 64'(cnt), 64'(exp_wait));
    check("gnt", 64'(o_gnt), 64'(4'b0001 << cur));
    check("gnt_id", 64'(o_gnt_id), 64'(cur));
    check("busy", 64'(o_busy), 1);
    check("kc_mode", 64'(o_kc_mode), 64'(cur));
    check("kc_ilen", 64'(o_kc_ibytes_len), 64'(31 + cur));
    check("kc_olen", 64'(o_kc_obytes_len), 64'(30 + cur));
  endtask

  task automatic do_txn(input int unsigned nabs, input logic [3:0] mid_req, input int unsigned exp_wait);
    int unsigned cur;
    logic [63:0] ob;
    wait_grant(cur, exp_wait);
    i_req = mid_req;
    for (int unsigned j = 0; j < nabs; j++) begin
      set_words(j);
      i_kc_ibytes_ready = 1'b1;
      #1;
      check("ib_ready", 64'(o_req_ibytes_ready), 64'(4'b0001 << cur));
      check("kc_ibytes", o_kc_ibytes, {32'(cur), 32'(j)});
      check("kc_ivalid", 64'(o_kc_ibytes_valid), 1);
      check("gnt_hold", 64'(o_gnt), 64'(4'b0001 << cur));
      @(negedge clk);
    end
    i_kc_ibytes_ready = 1'b0;
    ob = {$urandom, $urandom};
    i_kc_obytes = ob;
    i_kc_obytes_valid = 1'b1;
    #1;
    check("ob_valid", 64'(o_req_obytes_valid), 64'(4'b0001 << cur));
    check("obytes", o_req_obytes, ob);
    @(negedge clk);
    i_kc_obytes_done = 1'b1;
    #1;
    check("ob_done", 64'(o_req_obytes_done), 64'(4'b0001 << cur));
    check("gnt_at_done", 64'(o_gnt), 64'(4'b0001 << cur));
    @(negedge clk);
    i_kc_obytes_valid = 1'b0;
    i_kc_obytes_done  = 1'b1;
    i_kc_ibytes_ready = 1'b1;
    #1;
    check("rel_gnt", 64'(o_gnt), 0);
    check("rel_busy", 64'(o_busy), 0);
    check("rel_ivalid", 64'(o_kc_ibytes_valid), 0);
    check("rel_fwd", {52'b0, o_req_ibytes_ready, o_req_obytes_done, o_req_obytes_valid}, 0);
    i_kc_obytes_done  = 1'b0;
    i_kc_ibytes_ready = 1'b0;
  endtask

  initial begin
    int unsigned cur;
    i_rstn = 1'b0;
    i_req = 4'hF;
    i_req_ibytes_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      i_req_mode[2*k +: 2]        = 2'(k);
      i_req_ibytes_len[11*k +: 11] = 11'(31 + k);
      i_req_obytes_len[10*k +: 10] = 10'(30 + k);
    end
    set_words(0);
    i_kc_ibytes_ready = 1'b1;
    i_kc_obytes = '0;
    i_kc_obytes_valid = 1'b1;
    i_kc_obytes_done = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_gnt", 64'(o_gnt), 0);
    check("rst_gnt_id", 64'(o_gnt_id), 0);
    check("rst_busy", 64'(o_busy), 0);
    check("rst_cfg", {41'b0, o_kc_mode, o_kc_ibytes_len, o_kc_obytes_len}, 0);
    check("rst_fwd", {51'b0, o_kc_ibytes_valid, o_req_ibytes_ready, o_req_obytes_done, o_req_obytes_valid}, 0);
    i_kc_ibytes_ready = 1'b0;
    i_kc_obytes_valid = 1'b0;
    i_kc_obytes_done  = 1'b0;
    i_rstn = 1'b1;

    // Fairness: all four requesting over eight transactions.
`ifdef KECCAK_ARB_PRIO0_EN
    for (int n = 0; n < 8; n++) exp_q.push_back(0);
`else
    for (int n = 0; n < 8; n++) exp_q.push_back(n % 4);
`endif
    do_txn(5, 4'hF, 0);
    for (int n = 1; n < 8; n++) do_txn(1, 4'hF, 2);

    // Lone requester 2, back-to-back.
    i_req = 4'b0100;
    exp_q.push_back(2);
    do_txn(5, 4'b0100, 2);
    exp_q.push_back(2);
    do_txn(2, 4'b1000, 2);

    // Requester 3 drops its request; requester 1 arrives mid-transaction.
    exp_q.push_back(3);
    do_txn(3, 4'b0010, 2);
    exp_q.push_back(1);
    do_txn(2, 4'b0001, 2);

    // Requester 0 drops its request while busy.
    exp_q.push_back(0);
    do_txn(2, 4'b0000, 0);

    // Reset in the middle of a squeeze.
    i_req = 4'b0100;
    exp_q.push_back(2);
    wait_grant(cur, 0);
    i_req = 4'b0000;
    i_kc_obytes_valid = 1'b1;
    #1;
    check("sq_valid", 64'(o_req_obytes_valid), 64'(4'b0001 << cur));
    @(negedge clk);
    i_rstn = 1'b0;
    @(negedge clk);
    i_kc_obytes_done = 1'b1;
    #1;
    check("mid_rst_gnt", 64'(o_gnt), 0);
    check("mid_rst_busy", 64'(o_busy), 0);
    check("mid_rst_id", 64'(o_gnt_id), 0);
    check("mid_rst_done", 64'(o_req_obytes_done), 0);
    check("mid_rst_valid", 64'(o_req_obytes_valid), 0);
    @(negedge clk);
    i_kc_obytes_done  = 1'b0;
    i_kc_obytes_valid = 1'b0;
    i_rstn = 1'b1;
    i_req  = 4'hF;
    exp_q.push_back(0);
    do_txn(1, 4'b0000, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
